// File: rtl/seg_mux_if.sv
// Handshake bundle between the counter datapaths and the shared seven-segment scheduler.
interface seg_mux_if #(parameter int DWELL_W = 8);
  logic               ena;
  logic [3:0]         req;
  logic [15:0]        data;
  logic [1:0]         mode;
  logic [1:0]         man_sel;
  logic [DWELL_W-1:0] dwell;
  logic [6:0]         seg;
  logic [3:0]         grant;
  logic [1:0]         cur_id;
  logic               busy;

  modport master (output ena, req, data, mode, man_sel, dwell,
                  input  seg, grant, cur_id, busy);
  modport slave  (input  ena, req, data, mode, man_sel, dwell,
                  output seg, grant, cur_id, busy);
endinterface

// File: rtl/seg_mux_scheduler.sv
// Shares one hex seven-segment display between four nibble sources:
// manual / round-robin / priority selection, programmable dwell, fixed blank gap.
module seg_hex_dec (
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  always_comb begin
    case (nib)
      4'h0: seg = 7'h3F;  4'h1: seg = 7'h06;  4'h2: seg = 7'h5B;  4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;  4'h5: seg = 7'h6D;  4'h6: seg = 7'h7D;  4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;  4'h9: seg = 7'h6F;  4'hA: seg = 7'h77;  4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;  4'hD: seg = 7'h5E;  4'hE: seg = 7'h79;  default: seg = 7'h71;
    endcase
  end
endmodule

module seg_mux_scheduler #(
  parameter int BLANK_CYC = 2,
  parameter int DWELL_W   = 8
) (
  input logic        clk,
  input logic        rst_n,
  seg_mux_if.slave   bus
);
  localparam int NUM_SRC = 4;
  localparam int BW      = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
  localparam logic [BW-1:0] BLANK_LD = BW'(BLANK_CYC - 1);

  localparam logic [1:0] M_MAN = 2'b00;
  localparam logic [1:0] M_RR  = 2'b01;
  localparam logic [1:0] M_PRI = 2'b10;
  localparam logic [1:0] M_OFF = 2'b11;

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} state_t;

  state_t               state_q, state_d;
  logic [6:0]           seg_q, seg_d;
  logic [NUM_SRC-1:0]   grant_q, grant_d;
  logic [1:0]           cur_id_q, cur_id_d;
  logic                 busy_q, busy_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d, dwell_ld;
  logic [BW-1:0]        blank_q, blank_d;
  logic [1:0]           gmode_q, gmode_d;

  logic                 cand_vld, preempt, go_idle, go_blank;
  logic [1:0]           cand_id;
  logic [NUM_SRC-1:0][6:0] dec_seg;

  genvar g;
  generate
    for (g = 0; g < NUM_SRC; g++) begin : g_dec
      seg_hex_dec u_dec (.nib(bus.data[4*g +: 4]), .seg(dec_seg[g]));
    end
  endgenerate

  // Scan order cur+1, cur+2, cur+3, cur; the last hit in a descending loop is the first in scan order.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
    logic [2:0] res;
    logic [1:0] idx;
    res = '0;
    for (int k = 4; k >= 1; k--) begin
      idx = base + 2'(k);
      if (r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [2:0] pri_pick(input logic [3:0] r);
    logic [2:0] res;
    res = '0;
    for (int k = 3; k >= 0; k--)
      if (r[k]) res = {1'b1, 2'(k)};
    return res;
  endfunction

  always_comb begin
    {cand_vld, cand_id} = 3'b0;
    case (bus.mode)
      M_MAN:   {cand_vld, cand_id} = {1'b1, bus.man_sel};
      M_RR:    {cand_vld, cand_id} = rr_pick(bus.req, cur_id_q);
      M_PRI:   {cand_vld, cand_id} = pri_pick(bus.req);
      default: {cand_vld, cand_id} = 3'b0;
    endcase
  end

  assign dwell_ld = (bus.dwell == '0) ? '0 : bus.dwell - DWELL_W'(1);
  // Losing the request only preempts grants made under a request-driven mode.
  assign preempt  = ((gmode_q == M_RR) || (gmode_q == M_PRI)) && !bus.req[cur_id_q];

  always_comb begin
    state_d  = state_q;
    seg_d    = seg_q;
    grant_d  = grant_q;
    cur_id_d = cur_id_q;
    busy_d   = busy_q;
    dwell_d  = dwell_q;
    blank_d  = blank_q;
    gmode_d  = gmode_q;
    go_idle  = 1'b0;
    go_blank = 1'b0;
    case (state_q)
      IDLE: if (cand_vld) go_blank = 1'b1;
      BLANK: begin
        if (bus.mode == M_OFF) go_idle = 1'b1;
        else if (blank_q == '0) begin
          state_d = SHOW;
          dwell_d = dwell_ld;
          seg_d   = dec_seg[cur_id_q];
        end else blank_d = blank_q - BW'(1);
      end
      SHOW: begin
        seg_d = dec_seg[cur_id_q];
        if (dwell_q != '0) dwell_d = dwell_q - DWELL_W'(1);
        if (bus.mode == M_OFF) go_idle = 1'b1;
        else if ((dwell_q == '0) || preempt) begin
          if (!cand_vld)                go_idle  = 1'b1;
          else if (cand_id != cur_id_q) go_blank = 1'b1;
          else begin
            dwell_d = dwell_ld;
            gmode_d = bus.mode;
          end
        end
      end
      default: go_idle = 1'b1;
    endcase
    if (go_blank) begin
      state_d  = BLANK;
      cur_id_d = cand_id;
      grant_d  = 4'b0001 << cand_id;
      busy_d   = 1'b1;
      seg_d    = '0;
      blank_d  = BLANK_LD;
      gmode_d  = bus.mode;
    end
    if (go_idle) begin
      state_d = IDLE;
      seg_d   = '0;
      grant_d = '0;
      busy_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      seg_q    <= '0;
      grant_q  <= '0;
      cur_id_q <= '0;
      busy_q   <= 1'b0;
      dwell_q  <= '0;
      blank_q  <= '0;
      gmode_q  <= M_MAN;
    end else if (bus.ena) begin
      state_q  <= state_d;
      seg_q    <= seg_d;
      grant_q  <= grant_d;
      cur_id_q <= cur_id_d;
      busy_q   <= busy_d;
      dwell_q  <= dwell_d;
      blank_q  <= blank_d;
      gmode_q  <= gmode_d;
    end
  end

  assign bus.seg    = seg_q;
  assign bus.grant  = grant_q;
  assign bus.cur_id = cur_id_q;
  assign bus.busy   = busy_q;
endmodule

// File: tb/tb_seg_mux_scheduler.sv
// Directed plus randomized checking of seg_mux_scheduler against a phase/time-left reference model.
module tb_seg_mux_scheduler;
  localparam int BLANK_CYC = 2;
  localparam int DWELL_W   = 8;

  logic clk, rst_n;
  int   checks = 0;
  int   fails  = 0;

  seg_mux_if #(.DWELL_W(DWELL_W)) bus ();
  seg_mux_scheduler #(.BLANK_CYC(BLANK_CYC), .DWELL_W(DWELL_W)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: phase 0 idle, 1 blank, 2 show; m_left = cycles remaining in the current phase.
  int         m_phase, m_id, m_left, m_gmode;
  logic [6:0] m_seg;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic int pick(input int md, input logic [3:0] r, input int ms, input int id);
    if (md == 0) return ms;
    if (md == 1) begin
      for (int s = 1; s <= 4; s++) if (r[(id + s) % 4]) return (id + s) % 4;
      return -1;
    end
    if (md == 2) begin
      for (int s = 0; s < 4; s++) if (r[s]) return s;
      return -1;
    end
    return -1;
  endfunction

  function automatic logic [6:0] src_seg(input int id);
    logic [15:0] d;
    d = bus.data;
    return hex7(d[4*id +: 4]);
  endfunction

  task automatic m_reset();
    m_phase = 0; m_id = 0; m_left = 0; m_gmode = 0; m_seg = '0;
  endtask

  task automatic m_blank(input int c);
    m_phase = 1; m_id = c; m_left = BLANK_CYC; m_gmode = int'(bus.mode); m_seg = '0;
  endtask

  task automatic m_idle();
    m_phase = 0; m_seg = '0;
  endtask

  task automatic m_step();
    int c, dw;
    if (!bus.ena) return;
    c  = pick(int'(bus.mode), bus.req, int'(bus.man_sel), m_id);
    dw = (bus.dwell == 0) ? 1 : int'(bus.dwell);
    case (m_phase)
      0: if (c >= 0) m_blank(c);
      1: begin
        if (bus.mode == 2'b11) m_idle();
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_left = dw; m_seg = src_seg(m_id); end
        end
      end
      default: begin
        m_seg = src_seg(m_id);
        m_left--;
        if (bus.mode == 2'b11) m_idle();
        else if (m_left == 0 || ((m_gmode == 1 || m_gmode == 2) && !bus.req[m_id])) begin
          if (c < 0) m_idle();
          else if (c != m_id) m_blank(c);
          else begin m_left = dw; m_gmode = int'(bus.mode); end
        end
      end
    endcase
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".seg"},    32'(bus.seg),    32'(m_seg));
    check({tag, ".grant"},  32'(bus.grant),  (m_phase == 0) ? 32'd0 : (32'd1 << m_id));
    check({tag, ".cur_id"}, 32'(bus.cur_id), 32'(m_id));
    check({tag, ".busy"},   32'(bus.busy),   32'(m_phase != 0));
  endtask

  task automatic tick(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      m_step();
      #1;
      check_model(tag);
    end
  endtask

  task automatic sync_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    m_reset();
  endtask

  task automatic areset(input string tag);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    check({tag, ".seg"},   32'(bus.seg),   32'd0);
    check({tag, ".grant"}, 32'(bus.grant), 32'd0);
    check({tag, ".busy"},  32'(bus.busy),  32'd0);
    check({tag, ".cur"},   32'(bus.cur_id), 32'd0);
    #2 rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.ena = 1'b1; bus.req = '0; bus.data = '0; bus.mode = 2'b11;
    bus.man_sel = '0; bus.dwell = '0;
    m_reset();
    repeat (2) @(posedge clk);
    #1 check_model("reset");
    @(negedge clk) rst_n = 1'b1;

    // Round-robin between src0 and src2
    bus.mode = 2'b01; bus.req = 4'b0101; bus.dwell = 8'd3; bus.data = 16'h4321;
    tick("rr", 30);

    // Priority: src3 alone, then src1 joins mid-dwell
    sync_reset();
    bus.mode = 2'b10; bus.req = 4'b1000;
    tick("pri_a", 4);
    bus.req = 4'b1010;
    tick("pri_b", 12);

    // Manual select of src2 from IDLE, then move to src0
    sync_reset();
    bus.mode = 2'b00; bus.req = 4'b0000; bus.man_sel = 2'd2; bus.data = 16'h4A21;
    tick("man", 3);
    check("man.seg77", 32'(bus.seg), 32'h77);
    tick("man", 2);
    bus.man_sel = 2'd0;
    tick("man_sw", 10);

    // Single requester, then its request drops
    sync_reset();
    bus.mode = 2'b01; bus.req = 4'b0001; bus.dwell = 8'd3;
    tick("single", 10);
    bus.req = 4'b0000;
    tick("drop", 1);
    check("drop.seg",   32'(bus.seg),   32'd0);
    check("drop.grant", 32'(bus.grant), 32'd0);
    check("drop.busy",  32'(bus.busy),  32'd0);

    // Mode off mid-SHOW, then async reset mid-BLANK
    bus.req = 4'b0010;
    tick("pre_off", 5);
    bus.mode = 2'b11;
    tick("off", 1);
    check("off.busy", 32'(bus.busy), 32'd0);
    bus.mode = 2'b01;
    tick("reblank", 2);
    areset("areset");
    tick("post_rst", 4);

    // Zero dwell round-robin over all sources with an ena freeze
    sync_reset();
    bus.mode = 2'b01; bus.req = 4'b1111; bus.dwell = 8'd0; bus.data = 16'hC5E7;
    tick("dw0", 9);
    bus.ena = 1'b0;
    tick("freeze", 5);
    bus.ena = 1'b1;
    tick("dw0_b", 12);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.req     = 4'($urandom);
        bus.mode    = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
        bus.man_sel = 2'($urandom);
        bus.dwell   = 8'($urandom_range(0, 4));
      end
      if ($urandom_range(0, 2) == 0) bus.data = 16'($urandom);
      bus.ena = ($urandom_range(0, 7) != 0);
      tick("rand", 1);
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/seg_mux_scheduler.md
# seg_mux_scheduler

Time-multiplexing scheduler that shares one seven-segment hex decoder/display between four 4-bit counter sources. It sits between the counter datapaths and the `uo_out[6:0]` segment pins. It picks the source to show in one of three modes: manual, round-robin, or fixed priority. Each displayed value is held for a programmable dwell time, and the display is blanked for a fixed gap on every source change.

## Interface
Parameters:
- `BLANK_CYC`, default 2: cycles of blank segments between sources (≥1).
- `DWELL_W`, default 8: width of the dwell input and the dwell counter.

Ports:
- `clk` in 1: single clock; all state is rising-edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `ena` in 1: when 0, all registers hold their value.
- `req` in 4: per-source display request; bit i belongs to source i.
- `data` in 16: source nibbles; source i is `data[4i+3:4i]`.
- `mode` in 2: 00 manual, 01 round-robin, 10 priority, 11 off.
- `man_sel` in 2: source index used in manual mode.
- `dwell` in DWELL_W: minimum SHOW cycles per grant; 0 is treated as 1.
- `seg` out 7: active-high segments, `seg[0]`=a … `seg[6]`=g.
- `grant` out 4: one-hot displayed source; all zero in IDLE.
- `cur_id` out 2: index of the granted source.
- `busy` out 1: high in BLANK and SHOW.

## Operation
- States: IDLE, BLANK, SHOW.
- All outputs are registered.
- Reset values: state IDLE, `seg`=0, `grant`=0, `cur_id`=0, `busy`=0, dwell counter 0, blank counter 0.

Candidate selection, evaluated combinationally each cycle:
- Manual: candidate = `man_sel`; `req` is ignored.
- Round-robin: first set `req` bit scanning `cur_id+1`, `cur_id+2`, `cur_id+3`, `cur_id` (mod 4).
- Priority: lowest-index set `req` bit.
- Off: no candidate. Modes 01/10 with `req`=0: no candidate.

Transitions:
- IDLE → BLANK when a candidate exists. Load `cur_id`/`grant` = candidate and the blank counter = `BLANK_CYC`-1.
- BLANK: `seg`=0. Decrement the blank counter. At 0 → SHOW, load the dwell counter = max(`dwell`,1)-1, and load `seg` = decode(`data` of `cur_id`).
- SHOW, every cycle: `seg` <= decode(current nibble of `cur_id`), i.e. live tracking with 1-cycle latency. Decrement the dwell counter while it is nonzero.
- SHOW, at a decision point (dwell counter = 0):
  - If candidate ≠ `cur_id`: → BLANK with the new id.
  - If candidate = `cur_id`: reload the dwell counter and stay in SHOW.
  - If there is no candidate: → IDLE.
- Preemption (before dwell expires):
  - mode 11: → IDLE on the next edge.
  - modes 01/10, when `req[cur_id]` falls: immediate decision. If a candidate exists → BLANK, else → IDLE.
  - Manual with `man_sel` ≠ `cur_id`: waits for dwell expiry.
- Mode change: takes effect at the next decision point, except mode 11, which is immediate.
- In IDLE and BLANK, `seg`=0. In IDLE, `grant`=0.

Hex decode (gfedcba):
- 0:3F, 1:06, 2:5B, 3:4F, 4:66, 5:6D, 6:7D, 7:07
- 8:7F, 9:6F, A:77, b:7C, C:39, d:5E, E:79, F:71

## Timing
- Request to first displayed value: 1 (IDLE→BLANK) + `BLANK_CYC` cycles.
- In SHOW, data change to `seg` change: 1 cycle.
- Each grant lasts exactly max(`dwell`,1) SHOW cycles before re-evaluation, unless preempted.
- `rst_n` low mid-operation clears everything immediately, with no clock needed. The first candidate is evaluated on the first edge after release.
- `ena`=0 freezes all counters and outputs. Inputs are re-sampled when `ena` returns to 1.
- Round-robin wraps from 3 to 0.
- A single requester stays in SHOW indefinitely, with no blank gaps.

## Test plan
- Reset, then round-robin with `req`=0101, `dwell`=3 and `data`=0x0000_4_3_2_1 style nibbles (src0=1, src2=3):
  - `grant` goes 0001 → 0100 → 0001.
  - `seg` shows 06, then 00 for 2 cycles, then 4F, repeating.
  - Each value is held for 3 cycles.
- Priority mode, `req`=1000 then `req`=1010 mid-dwell:
  - src3 completes its dwell, then BLANK, then src1 (`cur_id`=1).
- Manual mode, `man_sel`=2, `data[11:8]`=A, with `req`=0:
  - `seg`=77 is reached after 3 cycles.
  - Changing `man_sel` to 0 switches only after dwell expires.
- In SHOW, `req[cur_id]` drops with no other request:
  - Next edge → IDLE, with `seg`=0, `grant`=0, `busy`=0.
- Mode 11 mid-SHOW:
  - → IDLE on the next edge.
  - Then `rst_n` pulsed low asynchronously mid-BLANK: all outputs are 0 without a clock edge.
- `dwell`=0, round-robin with `req`=1111:
  - Grants go 0→1→2→3→0, each with 1 SHOW cycle followed by a 2-cycle blank.
  - With `ena`=0 for 5 cycles mid-sequence, outputs are frozen.
